// File: rtl/lru_array.sv
// rtl/lru_array.sv - 256-set, 2-way LRU/valid tracker with victim lookup and flush
// Holds one LRU bit and two valid bits per set; a flush walks every set clearing it.
module lru_array (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic [7:0]   upd_index,
  input  logic         upd_way,
  input  logic         upd_fill,
  input  logic         lookup_req,
  input  logic [7:0]   lookup_index,
  output logic         victim_vld,
  output logic         victim_way,
  input  logic         flush_req,
  output logic         flush_busy,
  output logic         flush_done,
  output logic [255:0] lru_bits
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t       state;
  logic [7:0]   fcnt;
  logic [255:0] lru;
  logic [255:0] v0;
  logic [255:0] v1;
  logic         victim_next;

  assign upd_ready  = (state == IDLE);
  assign flush_busy = (state == FLUSH);
  assign lru_bits   = lru;

  // Invalid ways are always chosen first; way 0 wins when both are empty.
  always_comb begin
    victim_next = 1'b0;
    if (!v0[lookup_index])      victim_next = 1'b0;
    else if (!v1[lookup_index]) victim_next = 1'b1;
    else                        victim_next = lru[lookup_index];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fcnt       <= 8'd0;
      lru        <= '0;
      v0         <= '0;
      v1         <= '0;
      victim_vld <= 1'b0;
      victim_way <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      victim_vld <= lookup_req;
      if (lookup_req) victim_way <= victim_next;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_valid) begin
            lru[upd_index] <= ~upd_way;
            if (upd_fill) begin
              if (upd_way) v1[upd_index] <= 1'b1;
              else         v0[upd_index] <= 1'b1;
            end
          end
          if (flush_req) begin
            state <= FLUSH;
            fcnt  <= 8'd0;
          end
        end
        FLUSH: begin
          lru[fcnt] <= 1'b0;
          v0[fcnt]  <= 1'b0;
          v1[fcnt]  <= 1'b0;
          fcnt      <= fcnt + 8'd1;
          if (fcnt == 8'hff) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lru_array.sv
// tb/tb_lru_array.sv - directed scoreboard bench for lru_array
module tb_lru_array;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         upd_valid;
  logic         upd_ready;
  logic [7:0]   upd_index;
  logic         upd_way;
  logic         upd_fill;
  logic         lookup_req;
  logic [7:0]   lookup_index;
  logic         victim_vld;
  logic         victim_way;
  logic         flush_req;
  logic         flush_busy;
  logic         flush_done;
  logic [255:0] lru_bits;

  int tests = 0;
  int fails = 0;
  logic exp_q[$];
  logic exp_v;

  always #5 clk = ~clk;

  lru_array dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_way(upd_way), .upd_fill(upd_fill),
    .lookup_req(lookup_req), .lookup_index(lookup_index),
    .victim_vld(victim_vld), .victim_way(victim_way),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .lru_bits(lru_bits)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Victim scoreboard: every victim_vld pulse consumes one queued expectation.
  always @(posedge clk) begin
    #1;
    if (victim_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("victim_unexpected", 256'(victim_vld), 256'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("victim_way", 256'(victim_way), 256'(exp_v));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [7:0] idx, input logic way, input logic fill);
    upd_valid = 1'b1; upd_index = idx; upd_way = way; upd_fill = fill;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] idx, input logic exp);
    lookup_req = 1'b1; lookup_index = idx;
    exp_q.push_back(exp);
    step();
    lookup_req = 1'b0;
    step();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; upd_valid = 1'b0; upd_index = '0; upd_way = 1'b0; upd_fill = 1'b0;
    lookup_req = 1'b0; lookup_index = '0; flush_req = 1'b0;
    #12;
    check("rst_victim_vld", 256'(victim_vld), 256'd0);
    check("rst_victim_way", 256'(victim_way), 256'd0);
    check("rst_flush_busy", 256'(flush_busy), 256'd0);
    check("rst_flush_done", 256'(flush_done), 256'd0);
    check("rst_lru_bits", lru_bits, 256'd0);
    rst_n = 1'b1;
    step();
    check("rst_upd_ready", 256'(upd_ready), 256'd1);

    // Empty set picks way 0
    lookup(8'd5, 1'b0);

    update(8'd7, 1'b0, 1'b1);
    check("lru7_after_fill0", 256'(lru_bits[7]), 256'd1);
    update(8'd7, 1'b1, 1'b1);
    check("lru7_after_fill1", 256'(lru_bits[7]), 256'd0);
    lookup(8'd7, 1'b0);

    update(8'd200, 1'b0, 1'b1);
    update(8'd200, 1'b1, 1'b1);
    update(8'd200, 1'b0, 1'b0);
    check("lru200_access0", 256'(lru_bits[200]), 256'd1);
    lookup(8'd200, 1'b1);
    update(8'd200, 1'b1, 1'b0);
    check("lru200_access1", 256'(lru_bits[200]), 256'd0);
    lookup(8'd200, 1'b0);

    // Same-cycle lookup and update: old LRU is returned
    update(8'd3, 1'b1, 1'b1);
    update(8'd3, 1'b0, 1'b1);
    check("lru3_pre", 256'(lru_bits[3]), 256'd1);
    upd_valid = 1'b1; upd_index = 8'd3; upd_way = 1'b1; upd_fill = 1'b0;
    lookup_req = 1'b1; lookup_index = 8'd3; exp_q.push_back(1'b1);
    step();
    upd_valid = 1'b0; lookup_req = 1'b0;
    step();
    lookup(8'd3, 1'b0);

    // Only way 0 valid -> way 1 is the victim, and victim_way holds while idle
    update(8'd50, 1'b0, 1'b1);
    lookup(8'd50, 1'b1);
    step(); step();
    check("victim_hold_vld", 256'(victim_vld), 256'd0);
    check("victim_hold_way", 256'(victim_way), 256'd1);

    // Flush with a simultaneous accepted update, then a held update that must be dropped
    flush_req = 1'b1;
    upd_valid = 1'b1; upd_index = 8'd9; upd_way = 1'b0; upd_fill = 1'b1;
    step();
    flush_req = 1'b0;
    check("flush_accept_lru9", 256'(lru_bits[9]), 256'd1);
    check("flush_upd_ready", 256'(upd_ready), 256'd0);
    upd_index = 8'd10;
    n = 0;
    while (flush_busy === 1'b1 && n < 400) begin
      n++;
      if (flush_done !== 1'b0) check("flush_done_early", 256'(flush_done), 256'd0);
      lookup_req = (n == 1 || n == 100);
      lookup_index = 8'd50;
      if (n == 1)   exp_q.push_back(1'b1);
      if (n == 100) exp_q.push_back(1'b0);
      step();
    end
    upd_valid = 1'b0; lookup_req = 1'b0;
    check("flush_cycles", 256'(n), 256'd256);
    check("flush_done_pulse", 256'(flush_done), 256'd1);
    check("flush_lru_bits", lru_bits, 256'd0);

    // Back-to-back flush started in the done cycle, with an update landing at the same edge
    flush_req = 1'b1;
    upd_valid = 1'b1; upd_index = 8'd250; upd_way = 1'b0; upd_fill = 1'b1;
    step();
    flush_req = 1'b0; upd_valid = 1'b0;
    check("flush2_busy", 256'(flush_busy), 256'd1);
    check("flush2_done_low", 256'(flush_done), 256'd0);
    lookup(8'd10, 1'b0);
    lookup(8'd9, 1'b0);
    for (int i = 0; i < 96; i++) step();
    check("flush2_lru250", 256'(lru_bits[250]), 256'd1);
    lookup_req = 1'b1; lookup_index = 8'd250; exp_q.push_back(1'b1);
    step();
    lookup_req = 1'b0;

    // Reset mid-flush aborts immediately
    #2 rst_n = 1'b0;
    #1;
    check("abort_lru_bits", lru_bits, 256'd0);
    check("abort_busy", 256'(flush_busy), 256'd0);
    check("abort_victim_vld", 256'(victim_vld), 256'd0);
    check("abort_victim_way", 256'(victim_way), 256'd0);
    check("abort_upd_ready", 256'(upd_ready), 256'd1);
    step(); step();
    rst_n = 1'b1;
    step();
    check("abort_ready_after", 256'(upd_ready), 256'd1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (flush_done !== 1'b0 || flush_busy !== 1'b0) n++;
      step();
    end
    check("abort_no_done", 256'(n), 256'd0);
    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lru_array.md
LRU_ARRAY -- requirements
Module: lru_array

Interface
REQ-001 The block SHALL have no parameters; the geometry is fixed at 256 sets, 2 ways, 8-bit index.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 upd_valid  input  1  access-update request.
REQ-005 upd_ready  output  1  update can be accepted; equals (state==IDLE).
REQ-006 upd_index  input  8  set index being updated.
REQ-007 upd_way  input  1  way just accessed.
REQ-008 upd_fill  input  1  update is a fill; also marks upd_way valid.
REQ-009 lookup_req  input  1  victim lookup request.
REQ-010 lookup_index  input  8  set index for lookup.
REQ-011 victim_vld  output  1  registered; high one cycle after an accepted lookup.
REQ-012 victim_way  output  1  registered victim way for the last lookup.
REQ-013 flush_req  input  1  start a full-array clear.
REQ-014 flush_busy  output  1  high while state==FLUSH.
REQ-015 flush_done  output  1  one-cycle pulse at flush completion.
REQ-016 lru_bits  output  256  current LRU bit per set; bit i = set i; feeds the downstream 256:1 LRU select mux.

Function
REQ-017 Storage SHALL be lru[255:0], v0[255:0], v1[255:0]; lru[i]=1 means way 1 is LRU for set i.
REQ-018 An update SHALL be accepted when upd_valid && upd_ready; lru[upd_index] <= ~upd_way at that edge.
REQ-019 An accepted update with upd_fill=1 SHALL also set v0 or v1 [upd_index] per upd_way; with upd_fill=0, valid bits are unchanged.
REQ-020 Updates with upd_ready=0 SHALL be dropped; the requester must hold upd_valid.
REQ-021 A lookup SHALL be accepted every cycle lookup_req=1, in any state; victim_vld <= lookup_req each cycle.
REQ-022 Victim rule on pre-edge state: !v0 -> 0; else !v1 -> 1; else lru[lookup_index].
REQ-023 A lookup and an accepted update to the same index in the same cycle SHALL return the pre-update victim (no forwarding).
REQ-024 victim_way SHALL hold its last value when victim_vld=0.
REQ-025 lru_bits SHALL be a direct wire of lru[255:0]; an update appears the cycle after acceptance.
REQ-026 FSM states SHALL be IDLE and FLUSH; an 8-bit flush counter fcnt.
REQ-027 IDLE + flush_req=1 -> FLUSH with fcnt=0; a simultaneous upd_valid is accepted (upd_ready=1 in IDLE) and applied at the same edge.
REQ-028 In FLUSH, each cycle SHALL clear lru, v0, v1 [fcnt] and increment fcnt; flush_req SHALL be ignored.
REQ-029 When fcnt==255 in FLUSH: clear entry 255, fcnt wraps to 0, state -> IDLE, flush_done=1 for exactly the following cycle; a flush occupies 256 cycles.
REQ-030 Lookups during FLUSH SHALL see the partially cleared array (cleared sets return victim 0).
REQ-031 flush_req arriving in the cycle flush_done is high SHALL start a new flush.

Reset
REQ-032 rst_n low SHALL immediately clear lru, v0, v1, fcnt; state=IDLE; victim_vld=0, victim_way=0, flush_done=0, flush_busy=0, lru_bits=0.
REQ-033 Reset asserted mid-flush SHALL abort it; no flush_done pulse is produced.
REQ-034 After reset release, upd_ready SHALL be 1 on the first edge.

Verification
REQ-035 Reset; lookup idx 5 -> next cycle victim_vld=1, victim_way=0.
REQ-036 Fill idx 7 way 0, then fill way 1, then lookup idx 7 -> victim_way=0 (lru[7]=0); lru_bits[7]=0.
REQ-037 Both ways of idx 200 valid; access way 0 (upd_fill=0) -> lru_bits[200]=1, lookup -> victim_way=1; access way 1 -> victim_way=0.
REQ-038 Same-cycle lookup+update idx 3 (old lru[3]=1, update way 1) -> victim_way=1; next lookup -> 0.
REQ-039 Fill several sets, flush_req -> flush_busy for 256 cycles, upd_ready=0, upd_valid dropped; flush_done one cycle; lru_bits=0; all lookups return 0.
REQ-040 Assert rst_n low at flush cycle 100 -> all outputs 0 immediately; no flush_done; upd_ready=1 after release.
